// File: rtl/oam_dma_bus_pkg.sv
// Shared CPU-side definitions for the OAM DMA engine and the high-page/external bus router.
package oam_dma_bus_pkg;

    typedef enum logic [1:0] {
        DmaIdle   = 2'd0,
        DmaStart  = 2'd1,
        DmaActive = 2'd2
    } dma_state_e;

    localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
    localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
    localparam logic [1:0]  T_CYCLE_LAST = 2'd3;

    localparam int unsigned DMA_LENGTH_DEF  = 160;
    localparam int unsigned START_DELAY_DEF = 1;

    localparam logic [7:0] ECHO_BASE   = 8'hE0;
    localparam logic [7:0] ECHO_OFFSET = 8'h20;

    // Pages E0..FF mirror WRAM at C0..DF, so DMA reads them from the mirror source.
    function automatic logic [7:0] dma_eff_page(input logic [7:0] src_hi);
        return (src_hi >= ECHO_BASE) ? 8'(src_hi - ECHO_OFFSET) : src_hi;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: holds the FF46 source page, the copy index and the bus-steal flag.
module oam_dma_engine
    import oam_dma_bus_pkg::*;
#(
    parameter int unsigned DMA_LENGTH  = DMA_LENGTH_DEF,
    parameter int unsigned START_DELAY = START_DELAY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic        i_reg_wr,
    input  logic [7:0]  i_reg_data,
    input  logic [7:0]  i_bus_data,
    output logic [7:0]  o_src_hi,
    output logic        o_blocking,
    output logic [15:0] o_dma_addr_c,
    output logic        o_dma_en_c,
    output logic        o_oam_write_c,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_data_c
);

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LENGTH - 1);
    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

    dma_state_e r_state;
    logic [7:0] r_src_hi;
    logic [7:0] r_index;
    logic [7:0] r_delay;
    logic       r_blocking;
    logic       w_mcycle_end;

    assign w_mcycle_end = (t_cycle == T_CYCLE_LAST);

    // All state advances at the end of an M-cycle; a FF46 write overrides any other transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= DmaIdle;
            r_src_hi   <= 8'h00;
            r_index    <= 8'h00;
            r_delay    <= 8'h00;
            r_blocking <= 1'b0;
        end else if (w_mcycle_end) begin
            if (i_reg_wr) begin
                r_src_hi <= i_reg_data;
                r_index  <= 8'h00;
                r_delay  <= 8'h00;
                r_state  <= DmaStart;
            end else begin
                case (r_state)
                    DmaStart: begin
                        if (r_delay == DELAY_LAST) begin
                            r_delay    <= 8'h00;
                            r_state    <= DmaActive;
                            r_blocking <= 1'b1;
                        end else begin
                            r_delay <= 8'(r_delay + 8'd1);
                        end
                    end
                    DmaActive: begin
                        if (r_index == LAST_IDX) begin
                            r_index    <= 8'h00;
                            r_state    <= DmaIdle;
                            r_blocking <= 1'b0;
                        end else begin
                            r_index <= 8'(r_index + 8'd1);
                        end
                    end
                    default: begin
                        r_state <= DmaIdle;
                    end
                endcase
            end
        end
    end

    assign o_src_hi      = r_src_hi;
    assign o_blocking    = r_blocking;
    assign o_dma_en_c    = (r_state == DmaActive);
    assign o_dma_addr_c  = {dma_eff_page(r_src_hi), r_index};
    assign o_oam_write_c = o_dma_en_c && w_mcycle_end;
    assign o_oam_addr    = r_index;
    assign o_oam_data_c  = i_bus_data;

endmodule

// File: rtl/oam_dma_bus.sv
// CPU memory-port router: high page to IO/HRAM, everything else to the external bus,
// which the OAM DMA engine takes over while it is copying.
module oam_dma_bus
    import oam_dma_bus_pkg::*;
#(
    parameter int unsigned DMA_LENGTH   = DMA_LENGTH_DEF,
    parameter logic [15:0] DMA_REG_ADDR = ADDR_DMA_REG,
    parameter int unsigned START_DELAY  = START_DELAY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  io_addr,
    output logic        io_enable,
    output logic        io_write,
    output logic [7:0]  io_data_out,
    input  logic [7:0]  io_data_in,
    output logic        oam_write,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    logic        w_reg_hit;
    logic        w_high_page;
    logic        w_reg_wr;
    logic [7:0]  w_src_hi;
    logic        w_blocking;
    logic [15:0] w_dma_addr;
    logic        w_dma_en;

    assign w_reg_hit   = (cpu_addr == DMA_REG_ADDR);
    assign w_high_page = (cpu_addr[15:8] == HIGH_PAGE);
    assign w_reg_wr    = cpu_enable && cpu_write && w_reg_hit;

    oam_dma_engine #(
        .DMA_LENGTH  (DMA_LENGTH),
        .START_DELAY (START_DELAY)
    ) u_engine (
        .clk           (clk),
        .reset         (reset),
        .t_cycle       (t_cycle),
        .i_reg_wr      (w_reg_wr),
        .i_reg_data    (cpu_data_out),
        .i_bus_data    (bus_data_in),
        .o_src_hi      (w_src_hi),
        .o_blocking    (w_blocking),
        .o_dma_addr_c  (w_dma_addr),
        .o_dma_en_c    (w_dma_en),
        .o_oam_write_c (oam_write),
        .o_oam_addr    (oam_addr),
        .o_oam_data_c  (oam_data)
    );

    assign dma_active = w_blocking;

    // Strobes are held low while reset is asserted; data/address paths just follow the CPU.
    always_comb begin
        cpu_data_in  = 8'hFF;
        bus_addr     = cpu_addr;
        bus_enable   = 1'b0;
        bus_write    = 1'b0;
        bus_data_out = cpu_data_out;
        io_addr      = cpu_addr[7:0];
        io_enable    = 1'b0;
        io_write     = 1'b0;
        io_data_out  = cpu_data_out;

        if (w_reg_hit) begin
            cpu_data_in = w_src_hi;
        end else if (w_high_page) begin
            io_enable   = cpu_enable && reset;
            io_write    = cpu_write && reset;
            cpu_data_in = io_data_in;
        end else if (!w_blocking) begin
            bus_enable  = cpu_enable && reset;
            bus_write   = cpu_write && reset;
            cpu_data_in = bus_data_in;
        end

        if (w_blocking) begin
            bus_addr     = w_dma_addr;
            bus_enable   = w_dma_en && reset;
            bus_write    = 1'b0;
            bus_data_out = 8'h00;
        end
    end

endmodule

// File: doc/oam_dma_bus.md
Name: oam_dma_bus

Overview:
- Sits directly downstream of the CPU memory port.
- Routes each CPU access either to the external bus (0x0000–0xFEFF) or to the high-page IO/HRAM bus (0xFF00–0xFFFF).
- Owns the OAM DMA register at FF46. A write to FF46 starts a 160-byte copy from {src, 8'h00} into OAM, and the copy steals the external bus while it runs.
- Uses the CPU's t_cycle phase so that all sampling matches the CPU's end-of-M-cycle convention (t_cycle == 3).

Parameters:
- DMA_LENGTH, 160: number of bytes copied per transfer.
- DMA_REG_ADDR, 16'hFF46: address of the DMA source/start register.
- START_DELAY, 1: M-cycles between the FF46 write and the first copy cycle.

Ports:
- clk  in  1  system clock (4 MHz)
- reset  in  1  synchronous reset, active-low: the block resets on a clk edge when reset == 0
- t_cycle  in  2  CPU T-cycle phase (0..3)
- cpu_addr  in  16  CPU bus address
- cpu_enable  in  1  CPU access enable
- cpu_write  in  1  CPU write enable
- cpu_data_out  in  8  CPU write data
- cpu_data_in  out  8  read data returned to the CPU
- bus_addr  out  16  external bus address
- bus_enable  out  1  external bus enable
- bus_write  out  1  external bus write
- bus_data_out  out  8  external bus write data
- bus_data_in  in  8  external bus read data
- io_addr  out  8  low byte of the high-page address
- io_enable  out  1  high-page enable
- io_write  out  1  high-page write
- io_data_out  out  8  high-page write data
- io_data_in  in  8  high-page read data
- oam_write  out  1  OAM write strobe, one clk wide at t_cycle == 3
- oam_addr  out  8  OAM byte index (0..159)
- oam_data  out  8  OAM write data
- dma_active  out  1  high while DMA owns the external bus

Behaviour:
- Registers and their reset values: state = Idle, src_hi = 8'h00, index = 0, blocking = 0.
- Outputs on reset: oam_write = 0, dma_active = 0, bus_enable = 0, bus_write = 0, io_enable = 0, io_write = 0.
- Reset low mid-transfer abandons the transfer at once. No further oam_write is issued after the reset edge.
- CPU FF46 write: when cpu_enable && cpu_write && cpu_addr == DMA_REG_ADDR at t_cycle == 3:
  - src_hi <= cpu_data_out, index <= 0, state <= Start.
  - blocking keeps its current value, so a restart during Active stays blocked.
  - The write is not forwarded to the io bus.
- CPU FF46 read returns src_hi combinationally. io_enable stays 0 for that access.
- State machine, with transitions taken only at t_cycle == 3:
  - Idle: no DMA activity.
  - Start: counts START_DELAY M-cycles, then goes to Active and sets blocking = 1.
  - Active: each M-cycle, bus_addr = {eff_hi, index}, bus_enable = 1, bus_write = 0.
    - At t_cycle == 3: oam_write = 1, oam_addr = index, oam_data = bus_data_in, then index++.
    - After index DMA_LENGTH-1 is written: state <= Idle, blocking <= 0.
- Effective source page: eff_hi = src_hi - 8'h20 when src_hi >= 8'hE0 (echo of WRAM); otherwise eff_hi = src_hi.
- dma_active = blocking. It rises on the clk edge that enters Active and falls on the edge after the last OAM write.
- CPU routing when not blocking:
  - cpu_addr[15:8] == 8'hFF: drive the io_* outputs from the CPU signals and set cpu_data_in = io_data_in.
  - Otherwise: drive the bus_* outputs from the CPU signals and set cpu_data_in = bus_data_in.
- CPU routing when blocking:
  - High-page accesses still pass to io (this covers HRAM and IO).
  - Any other CPU read returns 8'hFF.
  - Any other CPU write is dropped.
  - bus_* is driven by the DMA only.
- Simultaneous events:
  - An FF46 write on the same edge as the final copy: the restart wins. State goes to Start and blocking stays 1.
  - oam_write for the final byte still fires on that edge.
- Address and width rules: index is 8 bits; oam_addr = index[7:0]. No wrap is possible because the transfer stops at DMA_LENGTH-1.

Decomposition:
- Shared cpu package:
  - dma_state_e {DmaIdle, DmaStart, DmaActive}.
  - Constants ADDR_DMA_REG = 16'hFF46 and HIGH_PAGE = 8'hFF.
  - T_CYCLE_LAST = 2'd3, also used by cpu.
- One sub-module: oam_dma_engine. It holds the state machine, src_hi, index and the OAM port.
- The top level, oam_dma_bus, holds the routing and blocking mux.

Test Plan:
- Idle routing:
  - CPU reads C123 -> bus_addr = C123, cpu_data_in = bus_data_in (5A).
  - CPU writes FF80 = 3C -> io_addr = 80, io_write = 1, io_data_out = 3C, bus_enable = 0.
- Basic DMA:
  - CPU writes FF46 = C1 -> 1 M-cycle delay, then 160 M-cycles with bus_addr C100..C19F.
  - Each byte is written to oam_addr 0..159.
  - dma_active is high for exactly 160×4 clk.
  - FF46 reads back C1.
- Blocking:
  - During DMA, CPU reads 8000 -> cpu_data_in = FF, and bus_addr stays on the DMA address.
  - During DMA, CPU writes C000 = 12 -> dropped.
  - During DMA, CPU reads FF90 -> io path returns io_data_in.
- Echo source: FF46 = E2 -> bus_addr runs C200..C29F.
- Restart: FF46 = C0, then at index 50 FF46 = D0 -> dma_active stays 1, one delay M-cycle, then the copy resumes from D000 into oam_addr 0.
- Reset mid-transfer: drive reset = 0 at index 80 -> next edge gives oam_write = 0, dma_active = 0, FF46 reads 00, and CPU reads of C000 pass through.
